regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file for the pipelined core, successor to the 2R1W regfile.
//  Adds N read ports, an async reset clearing all registers, same-cycle write->read bypass,
//  and a per-register busy scoreboard. Decode uses the scoreboard for RAW stall detection.
//  Sits between decode (reads/issue) and writeback (writes/clears).
// PARAMETERS
//  XLEN    32  data width of each register
//  NREGS   32  register count; power of two; AW = $clog2(NREGS)
//  NUM_RD  2   number of independent read ports (1..4)
//  BYPASS  1   1: a write in the same cycle is forwarded to matching reads; 0: reads see stored value
// PORTS
//  clk       in   1            rising-edge clock
//  rst_n     in   1            asynchronous active-low reset
//  raddr     in   NUM_RD*AW    read addresses, port i at [i*AW +: AW]
//  rdata     out  NUM_RD*XLEN  read data, port i at [i*XLEN +: XLEN]
//  rbusy     out  NUM_RD       port i's register has a pending producer (stall request)
//  we        in   1            writeback enable
//  waddr     in   AW           writeback address
//  wdata     in   XLEN         writeback data
//  iss_en    in   1            issue: mark iss_addr busy (an instruction writing it issued)
//  iss_addr  in   AW           destination of the issued instruction
//  any_busy  out  1            OR of all busy bits (pipeline-drain indicator)
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers <= 0, all busy bits <= 0. No clock needed.
//   Outputs during reset: rdata=0, rbusy=0, any_busy=0.
//   Reset asserted mid-operation aborts pending writes and issues. First update is on the first clk edge after rst_n rises.
//  Register 0: reads always return 0, busy bit constant 0.
//   Writes and issues to address 0 are silently dropped.
//  Write: on posedge clk with we=1 and waddr!=0, reg[waddr] <= wdata. The same edge clears busy[waddr].
//  Issue: on posedge clk with iss_en=1 and iss_addr!=0, busy[iss_addr] <= 1.
//  Simultaneous issue and write to the same address: data is written and busy ends at 1.
//   The newer producer wins.
//  Simultaneous issue and write to different addresses: both take effect independently.
//  Reads are combinational (0-cycle latency) on every port independently. Duplicate addresses on several ports are allowed.
//   BYPASS=1, we=1, waddr==raddr[i]!=0: rdata[i]=wdata and rbusy[i]=0.
//   Otherwise: rdata[i]=reg[raddr[i]] and rbusy[i]=busy[raddr[i]].
//   Issue in the current cycle never affects current-cycle rbusy. It is visible from the next cycle.
//  Write to a register that is not busy is legal. Data updates; busy stays 0.
//  any_busy is registered-state-derived only. It ignores same-cycle we and iss_en.
//  Width rules: no arithmetic. Addresses >= NREGS are impossible because NREGS is a power of two.
// STRUCTURE
//  regfile_pkg: XLEN_DEF, NREGS_DEF, AW function/constant, and the reg-0 address constant REG_ZERO.
//  Storage: reg array [1:NREGS-1] plus busy vector [NREGS-1:0] (bit 0 tied low). Both sit in a
//   single always block sensitive to posedge clk / negedge rst_n.
//  Sub-module rf_read_port (XLEN, NREGS, BYPASS): one address-to-data mux, bypass compare and
//   busy select. Instantiated NUM_RD times in a generate loop.
// TESTING
//  1 Reset: write x5=0xDEADBEEF, issue x7, pulse rst_n low mid-cycle
//    -> rdata=0 and any_busy=0 immediately, without waiting for a clock edge.
//  2 Write/read: we, waddr=3, wdata=0x12345678 -> after the edge all NUM_RD ports reading 3 return 0x12345678.
//    Writing x0 with 0xFFFFFFFF -> x0 still reads 0.
//  3 Bypass: same cycle we, waddr=9, wdata=0xA5A5A5A5 and raddr0=9
//    -> BYPASS=1: rdata0=0xA5A5A5A5 combinationally. BYPASS=0: old value until the edge.
//  4 Scoreboard: issue x4 -> next cycle rbusy=1 on ports reading 4, any_busy=1.
//    Write x4=0x55 -> same-cycle rbusy=0 (BYPASS=1), and busy is cleared after the edge.
//  5 Collision: issue x6 and write x6=0x77 in the same cycle
//    -> after the edge reg6=0x77 and busy[6]=1. Issue x0 -> busy never set.
//  6 Multi-port: NUM_RD=4, all ports read distinct and duplicate addresses over a random write sequence
//    -> data matches a reference model each cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing defaults and address helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int NUM_RD_DEF = 2;

    // Register 0 is hardwired: reads return zero, writes and issues are dropped.
    localparam int REG_ZERO = 0;

    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int AW_DEF = addr_width(NREGS_DEF);

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register select, same-cycle write forwarding and busy select.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic [AW-1:0]               raddr,
    input  logic [NREGS-1:0][XLEN-1:0]  regs,
    input  logic [NREGS-1:0]            busy,
    input  logic                        wr_fwd,
    input  logic [AW-1:0]               waddr,
    input  logic [XLEN-1:0]             wdata,
    output logic [XLEN-1:0]             rdata,
    output logic                        rbusy
);

    logic hit;

    // wr_fwd is already qualified by the top (non-zero address, not in reset).
    if (BYPASS) begin : g_bypass
        assign hit = wr_fwd && (waddr == raddr);
    end else begin : g_no_bypass
        logic unused_fwd;
        assign unused_fwd = ^{wr_fwd, waddr, wdata};
        assign hit        = 1'b0;
    end

    always_comb begin
        rdata = regs[raddr];
        rbusy = busy[raddr];
        if (hit) begin
            rdata = wdata;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write bypass and a per-register busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     raddr,
    output logic [NUM_RD*XLEN-1:0]   rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic                     any_busy
);

    logic [XLEN-1:0]            regs_q [1:NREGS-1];
    logic [NREGS-1:1]           busy_q;
    logic [NREGS-1:0][XLEN-1:0] reg_view;
    logic [NREGS-1:0]           busy_view;
    logic                       wr_ok;
    logic                       iss_ok;
    logic                       wr_fwd;

    assign wr_ok  = we && (waddr != AW'(REG_ZERO));
    assign iss_ok = iss_en && (iss_addr != AW'(REG_ZERO));
    // Forwarding is suppressed in reset so every read port shows zero.
    assign wr_fwd = wr_ok && rst_n;

    // Issue is applied after the write so a same-cycle issue leaves the register busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[waddr] <= wdata;
                busy_q[waddr] <= 1'b0;
            end
            if (iss_ok) begin
                busy_q[iss_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        reg_view = '0;
        for (int i = 1; i < NREGS; i++) begin
            reg_view[i] = regs_q[i];
        end
    end

    assign busy_view = {busy_q, 1'b0};
    assign any_busy  = |busy_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        rf_read_port #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .BYPASS (BYPASS)
        ) u_port (
            .raddr  (raddr[g*AW +: AW]),
            .regs   (reg_view),
            .busy   (busy_view),
            .wr_fwd (wr_fwd),
            .waddr  (waddr),
            .wdata  (wdata),
            .rdata  (rdata[g*XLEN +: XLEN]),
            .rbusy  (rbusy[g])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one bypassing and one non-bypassing instance driven in parallel.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 4;
    localparam int OW    = 2 * XLEN + 2;

    logic                  clk;
    logic                  rst_n;
    logic [AW-1:0]         ra [NRD];
    logic [NRD*AW-1:0]     raddr;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [XLEN-1:0]       wdata;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;
    logic [NRD*XLEN-1:0]   rdata_b, rdata_n;
    logic [NRD-1:0]        rbusy_b, rbusy_n;
    logic                  any_b, any_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];
    logic [OW-1:0]   exp_q [$];

    always_comb begin
        raddr = '0;
        for (int p = 0; p < NRD; p++) begin
            raddr[p*AW +: AW] = ra[p];
        end
    end

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NRD), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .iss_en(iss_en), .iss_addr(iss_addr),
        .any_busy(any_b)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NRD), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .we(we), .waddr(waddr), .wdata(wdata), .iss_en(iss_en), .iss_addr(iss_addr),
        .any_busy(any_n)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] m_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && rst_n && we && waddr == a) return wdata;
        return m_mem[a];
    endfunction

    function automatic bit m_rb(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && rst_n && we && waddr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit m_any();
        for (int r = 0; r < NREGS; r++) begin
            if (m_busy[r]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [OW-1:0] port_exp(input int p);
        return {m_rd(ra[p], 1'b1), m_rb(ra[p], 1'b1), m_rd(ra[p], 1'b0), m_rb(ra[p], 1'b0)};
    endfunction

    function automatic logic [OW-1:0] port_obs(input int p);
        return {rdata_b[p*XLEN +: XLEN], rbusy_b[p], rdata_n[p*XLEN +: XLEN], rbusy_n[p]};
    endfunction

    task automatic m_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic m_update();
        if (we && waddr != 0) begin
            m_mem[waddr]  = wdata;
            m_busy[waddr] = 1'b0;
        end
        if (iss_en && iss_addr != 0) begin
            m_busy[iss_addr] = 1'b1;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        if (rst_n) m_update();
        #1;
    endtask

    task automatic set_idle();
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        iss_en = 1'b0;
        iss_addr = '0;
    endtask

    task automatic drv_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
    endtask

    task automatic drv_issue(input logic [AW-1:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    task automatic set_reads(input logic [AW-1:0] a0, a1, a2, a3);
        ra[0] = a0;
        ra[1] = a1;
        ra[2] = a2;
        ra[3] = a3;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        set_reads(0, 5, 7, 31);
        m_clear();
        #2;
        for (int p = 0; p < NRD; p++) begin
            n_checks++;
            if (port_obs(p) !== '0) begin
                n_fail++;
                $display("FAIL reset_state port%0d got=%h exp=%h", p, port_obs(p), {OW{1'b0}});
            end
        end
        n_checks++;
        if ({any_b, any_n} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_any got=%b exp=00", {any_b, any_n});
        end
        #1 rst_n = 1'b1;
        tick();
        drv_write(5, 32'hDEADBEEF);
        tick();
        set_idle();
        drv_issue(7);
        tick();
        set_idle();
        #1;
        n_checks++;
        if ({any_b, any_n} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_any got=%b exp=11", {any_b, any_n});
        end
        // Mid-cycle reset with a write pending: outputs must clear with no clock edge.
        drv_write(5, 32'h0BADF00D);
        #1 rst_n = 1'b0;
        m_clear();
        #1;
        for (int p = 0; p < NRD; p++) begin
            n_checks++;
            if (port_obs(p) !== '0) begin
                n_fail++;
                $display("FAIL async_reset port%0d got=%h exp=%h", p, port_obs(p), {OW{1'b0}});
            end
        end
        n_checks++;
        if ({any_b, any_n} !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_any got=%b exp=00", {any_b, any_n});
        end
        set_idle();
        #1 rst_n = 1'b1;
        tick();
        for (int p = 0; p < NRD; p++) begin
            n_checks++;
            if (port_obs(p) !== '0) begin
                n_fail++;
                $display("FAIL post_reset port%0d got=%h exp=%h", p, port_obs(p), {OW{1'b0}});
            end
        end
    endtask

    task automatic test_write_read();
        logic [OW-1:0] e;
        drv_write(3, 32'h12345678);
        set_reads(3, 3, 3, 3);
        tick();
        set_idle();
        #1;
        e = {32'h12345678, 1'b0, 32'h12345678, 1'b0};
        for (int p = 0; p < NRD; p++) begin
            n_checks++;
            if (port_obs(p) !== e) begin
                n_fail++;
                $display("FAIL write_read port%0d got=%h exp=%h", p, port_obs(p), e);
            end
        end
        drv_write(0, 32'hFFFFFFFF);
        set_reads(0, 0, 0, 0);
        #1;
        for (int p = 0; p < NRD; p++) begin
            n_checks++;
            if (port_obs(p) !== '0) begin
                n_fail++;
                $display("FAIL x0_same_cycle port%0d got=%h exp=0", p, port_obs(p));
            end
        end
        tick();
        set_idle();
        #1;
        for (int p = 0; p < NRD; p++) begin
            n_checks++;
            if (port_obs(p) !== '0) begin
                n_fail++;
                $display("FAIL x0_after_edge port%0d got=%h exp=0", p, port_obs(p));
            end
        end
    endtask

    task automatic test_bypass();
        logic [OW-1:0] e [NRD];
        drv_write(9, 32'h11112222);
        tick();
        drv_write(9, 32'hA5A5A5A5);
        set_reads(9, 3, 9, 0);
        #1;
        e[0] = {32'hA5A5A5A5, 1'b0, 32'h11112222, 1'b0};
        e[1] = {32'h12345678, 1'b0, 32'h12345678, 1'b0};
        e[2] = e[0];
        e[3] = '0;
        for (int p = 0; p < NRD; p++) begin
            n_checks++;
            if (port_obs(p) !== e[p]) begin
                n_fail++;
                $display("FAIL bypass_same_cycle port%0d got=%h exp=%h", p, port_obs(p), e[p]);
            end
        end
        tick();
        set_idle();
        #1;
        e[0] = {32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0};
        n_checks++;
        if (port_obs(0) !== e[0]) begin
            n_fail++;
            $display("FAIL bypass_after_edge port0 got=%h exp=%h", port_obs(0), e[0]);
        end
    endtask

    task automatic test_scoreboard();
        logic [OW-1:0] e;
        set_reads(4, 4, 5, 4);
        drv_issue(4);
        #1;
        n_checks++;
        if (port_obs(0) !== '0 || {any_b, any_n} !== 2'b00) begin
            n_fail++;
            $display("FAIL issue_same_cycle got=%h any=%b exp=0 any=00", port_obs(0), {any_b, any_n});
        end
        tick();
        set_idle();
        #1;
        e = {32'h0, 1'b1, 32'h0, 1'b1};
        for (int p = 0; p < NRD; p++) begin
            n_checks++;
            if (port_obs(p) !== ((p == 2) ? {OW{1'b0}} : e)) begin
                n_fail++;
                $display("FAIL issue_busy port%0d got=%h exp=%h", p, port_obs(p), (p == 2) ? {OW{1'b0}} : e);
            end
        end
        n_checks++;
        if ({any_b, any_n} !== 2'b11) begin
            n_fail++;
            $display("FAIL issue_any got=%b exp=11", {any_b, any_n});
        end
        drv_write(4, 32'h55);
        #1;
        e = {32'h55, 1'b0, 32'h0, 1'b1};
        n_checks++;
        if (port_obs(0) !== e || {any_b, any_n} !== 2'b11) begin
            n_fail++;
            $display("FAIL wb_same_cycle got=%h any=%b exp=%h any=11", port_obs(0), {any_b, any_n}, e);
        end
        tick();
        set_idle();
        #1;
        e = {32'h55, 1'b0, 32'h55, 1'b0};
        n_checks++;
        if (port_obs(1) !== e || {any_b, any_n} !== 2'b00) begin
            n_fail++;
            $display("FAIL wb_cleared got=%h any=%b exp=%h any=00", port_obs(1), {any_b, any_n}, e);
        end
    endtask

    task automatic test_collision();
        logic [OW-1:0] e [NRD];
        set_reads(6, 6, 0, 8);
        drv_write(6, 32'h77);
        drv_issue(6);
        tick();
        set_idle();
        #1;
        e[0] = {32'h77, 1'b1, 32'h77, 1'b1};
        n_checks++;
        if (port_obs(0) !== e[0] || {any_b, any_n} !== 2'b11) begin
            n_fail++;
            $display("FAIL collision got=%h any=%b exp=%h any=11", port_obs(0), {any_b, any_n}, e[0]);
        end
        drv_issue(0);
        tick();
        set_idle();
        #1;
        n_checks++;
        if (port_obs(2) !== '0) begin
            n_fail++;
            $display("FAIL issue_x0 got=%h exp=0", port_obs(2));
        end
        drv_write(6, 32'h88);
        drv_issue(8);
        tick();
        set_idle();
        #1;
        e[0] = {32'h88, 1'b0, 32'h88, 1'b0};
        e[3] = {32'h0, 1'b1, 32'h0, 1'b1};
        n_checks++;
        if (port_obs(0) !== e[0] || port_obs(3) !== e[3]) begin
            n_fail++;
            $display("FAIL split_wr_iss got=%h/%h exp=%h/%h", port_obs(0), port_obs(3), e[0], e[3]);
        end
        drv_write(8, 32'h99);
        tick();
        set_idle();
        #1;
        e[3] = {32'h99, 1'b0, 32'h99, 1'b0};
        n_checks++;
        if (port_obs(3) !== e[3] || {any_b, any_n} !== 2'b00) begin
            n_fail++;
            $display("FAIL drain got=%h any=%b exp=%h any=00", port_obs(3), {any_b, any_n}, e[3]);
        end
    endtask

    task automatic test_random_multiport();
        logic [OW-1:0] got;
        logic [OW-1:0] want;
        for (int c = 0; c < 300; c++) begin
            we       = ($urandom_range(0, 1) == 1);
            waddr    = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 7));
            wdata    = $urandom;
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = AW'($urandom_range(0, 7));
            for (int p = 0; p < NRD; p++) begin
                ra[p] = AW'($urandom_range(0, 1) == 0 ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
            end
            #1;
            for (int p = 0; p < NRD; p++) begin
                exp_q.push_back(port_exp(p));
            end
            for (int p = 0; p < NRD; p++) begin
                want = exp_q.pop_front();
                got  = port_obs(p);
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL random c%0d port%0d got=%h exp=%h", c, p, got, want);
                end
            end
            n_checks++;
            if ({any_b, any_n} !== {2{m_any()}}) begin
                n_fail++;
                $display("FAIL random_any c%0d got=%b exp=%b", c, {any_b, any_n}, {2{m_any()}});
            end
            tick();
        end
        set_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_random_multiport();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
